// File: rtl/nestn_cnt_pkg.sv
// Shared types and field-slice helpers for the nested tile address generator.
package nestn_cnt_pkg;

  localparam int unsigned NEST_MAX = 8;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  // LSB of level lvl inside the packed bound vector.
  function automatic int unsigned bound_lsb(input int unsigned lvl, input int unsigned cw);
    return lvl * cw;
  endfunction

  // LSB of level lvl inside the packed stride vector.
  function automatic int unsigned stride_lsb(input int unsigned lvl, input int unsigned aw);
    return lvl * aw;
  endfunction

endpackage

// File: rtl/nestn_level_cnt.sv
// One nesting level: trip counter plus running address offset, stepped by the carry chain.
module nestn_level_cnt
  import nestn_cnt_pkg::*;
#(
  parameter int unsigned CW = 16,
  parameter int unsigned AW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          step,
  input  logic          carry_in,
  input  logic [CW-1:0] bound,
  input  logic [AW-1:0] stride,
  output logic [CW-1:0] cnt,
  output logic [AW-1:0] off,
  output logic          wrap
);

  logic [CW-1:0] bound_q;
  logic [AW-1:0] stride_q;
  logic [CW-1:0] cnt_q;
  logic [AW-1:0] off_q;
  logic          at_max;

  // Compare against bound-1 so a full-scale bound never overflows the counter.
  assign at_max = (cnt_q == (bound_q - CW'(1)));
  assign wrap   = carry_in && at_max;
  assign cnt    = cnt_q;
  assign off    = off_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bound_q  <= '0;
      stride_q <= '0;
      cnt_q    <= '0;
      off_q    <= '0;
    end else if (load) begin
      bound_q  <= bound;
      stride_q <= stride;
      cnt_q    <= '0;
      off_q    <= '0;
    end else if (step && carry_in) begin
      if (at_max) begin
        cnt_q <= '0;
        off_q <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
        off_q <= off_q + stride_q;
      end
    end
  end

endmodule

// File: rtl/nestn_tile_addr_gen.sv
// Nested tile counter emitting (cnt tuple, linear address) beats under valid/ready.
// Optional NESTN_STALL_CNT_EN adds a saturating stall_cnt output.
module nestn_tile_addr_gen
  import nestn_cnt_pkg::*;
#(
  parameter int unsigned NEST = 4,
  parameter int unsigned CW   = 16,
  parameter int unsigned AW   = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               clean,
  input  logic [NEST*CW-1:0] bound,
  input  logic [NEST*AW-1:0] stride,
  input  logic [AW-1:0]      base,
`ifdef NESTN_STALL_CNT_EN
  output logic [31:0]        stall_cnt,
`endif
  output logic [NEST*CW-1:0] cnt,
  output logic [AW-1:0]      addr,
  output logic               valid,
  input  logic               ready,
  output logic               last,
  output logic               busy,
  output logic               done
);

  state_e        state_q;
  logic          valid_q;
  logic          done_q;
  logic          busy_q;
  logic [AW-1:0] base_q;

  logic [CW-1:0] bound_f [NEST];
  logic [CW-1:0] cnt_w   [NEST];
  logic [AW-1:0] off_w   [NEST];
  logic [NEST:0] carry;

  logic          any_zero;
  logic          start_ok;
  logic          load;
  logic          xfer;
  logic          step;
  logic [AW-1:0] addr_sum;

  assign start_ok = (state_q == StIdle) && start && !clean;
  assign load     = start_ok && !any_zero;
  assign xfer     = valid_q && ready;
  assign step     = xfer && !clean;
  assign carry[0] = 1'b1;

  always_comb begin
    any_zero = 1'b0;
    for (int unsigned i = 0; i < NEST; i++) begin
      if (bound_f[i] == '0) any_zero = 1'b1;
    end
  end

  for (genvar i = 0; i < NEST; i++) begin : g_level
    localparam int unsigned BoundLsb  = bound_lsb(i, CW);
    localparam int unsigned StrideLsb = stride_lsb(i, AW);

    assign bound_f[i]            = bound[BoundLsb +: CW];
    assign cnt[BoundLsb +: CW]   = cnt_w[i];

    nestn_level_cnt #(
      .CW(CW),
      .AW(AW)
    ) u_level (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (load),
      .step    (step),
      .carry_in(carry[i]),
      .bound   (bound_f[i]),
      .stride  (stride[StrideLsb +: AW]),
      .cnt     (cnt_w[i]),
      .off     (off_w[i]),
      .wrap    (carry[i+1])
    );
  end

  // The carry out of the top level is high exactly when every level sits at its maximum.
  assign last = valid_q && carry[NEST];

  always_comb begin
    addr_sum = base_q;
    for (int unsigned i = 0; i < NEST; i++) begin
      addr_sum = addr_sum + off_w[i];
    end
  end

  assign addr  = addr_sum;
  assign valid = valid_q;
  assign busy  = busy_q;
  assign done  = done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      base_q  <= '0;
    end else begin
      done_q <= 1'b0;
      if (clean) begin
        state_q <= StIdle;
        valid_q <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (start) begin
              busy_q <= 1'b1;
              if (any_zero) begin
                state_q <= StDone;
                done_q  <= 1'b1;
              end else begin
                state_q <= StRun;
                valid_q <= 1'b1;
                base_q  <= base;
              end
            end
          end
          StRun: begin
            if (xfer && last) begin
              state_q <= StDone;
              valid_q <= 1'b0;
              done_q  <= 1'b1;
            end
          end
          StDone: begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

`ifdef NESTN_STALL_CNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (start_ok) begin
      stall_q <= '0;
    end else if (valid_q && !ready && (stall_q != '1)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_nestn_tile_addr_gen.sv
// Self-checking bench: directed and randomized tile walks against an arithmetic tuple model.
module tb_nestn_tile_addr_gen;

  localparam int unsigned NEST = 3;
  localparam int unsigned CW   = 8;
  localparam int unsigned AW   = 32;

  logic               clk;
  logic               rst_n;
  logic               start;
  logic               clean;
  logic [NEST*CW-1:0] bound;
  logic [NEST*AW-1:0] stride;
  logic [AW-1:0]      base;
  logic [NEST*CW-1:0] cnt;
  logic [AW-1:0]      addr;
  logic               valid;
  logic               ready;
  logic               last;
  logic               busy;
  logic               done;
`ifdef NESTN_STALL_CNT_EN
  logic [31:0]        stall_cnt;
`endif

  nestn_tile_addr_gen #(
    .NEST(NEST),
    .CW  (CW),
    .AW  (AW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .clean    (clean),
    .bound    (bound),
    .stride   (stride),
    .base     (base),
`ifdef NESTN_STALL_CNT_EN
    .stall_cnt(stall_cnt),
`endif
    .cnt      (cnt),
    .addr     (addr),
    .valid    (valid),
    .ready    (ready),
    .last     (last),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  int unsigned bnd [NEST];
  int unsigned str [NEST];
  logic [31:0] bas;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Tuple for beat k: mixed-radix digits of k with level 0 least significant.
  function automatic logic [NEST*CW-1:0] m_cnt(input int unsigned k);
    logic [NEST*CW-1:0] r;
    int unsigned div, c;
    r   = '0;
    div = 1;
    for (int i = 0; i < NEST; i++) begin
      c = (k / div) % bnd[i];
      r[i*CW +: CW] = c[CW-1:0];
      div = div * bnd[i];
    end
    return r;
  endfunction

  function automatic logic [31:0] m_addr(input int unsigned k);
    int unsigned a, div;
    a   = bas;
    div = 1;
    for (int i = 0; i < NEST; i++) begin
      a   = a + ((k / div) % bnd[i]) * str[i];
      div = div * bnd[i];
    end
    return a;
  endfunction

  task automatic drive_cfg();
    for (int i = 0; i < NEST; i++) begin
      bound[i*CW +: CW]  = CW'(bnd[i]);
      stride[i*AW +: AW] = str[i];
    end
    base = bas;
  endtask

  task automatic check_zeros(input string tag);
    chk({tag, "_cnt"}, 64'(cnt), 64'd0);
    chk({tag, "_addr"}, 64'(addr), 64'd0);
    chk({tag, "_valid"}, 64'(valid), 64'd0);
    chk({tag, "_last"}, 64'(last), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
  endtask

  // mode 0: ready=1, 1: ready toggles 1/0, 2: random ready with scrambled inputs.
  task automatic walk(input int mode, input int clean_at);
    int total, k, cyc, stalls;
    total  = int'(bnd[0] * bnd[1] * bnd[2]);
    k      = 0;
    cyc    = 0;
    stalls = 0;
    drive_cfg();
    ready = 1'b0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    while (k < total && cyc < 20 * total + 50) begin
      if (k == clean_at) begin
        clean = 1'b1;
        ready = 1'($urandom_range(0, 1));
        @(posedge clk); #1 clean = 1'b0;
        start = 1'b0;
        chk("clean_valid", 64'(valid), 64'd0);
        chk("clean_busy", 64'(busy), 64'd0);
        chk("clean_done", 64'(done), 64'd0);
        chk("clean_cnt_hold", 64'(cnt), 64'(m_cnt(k)));
        chk("clean_addr_hold", 64'(addr), 64'(m_addr(k)));
        @(posedge clk); #1 chk("clean_no_done", 64'(done), 64'd0);
        return;
      end
      case (mode)
        0: ready = 1'b1;
        1: ready = (cyc % 2 == 0);
        default: begin
          ready  = 1'($urandom_range(0, 1));
          start  = 1'($urandom_range(0, 1));
          base   = $urandom;
          bound  = (NEST*CW)'($urandom);
          stride = {$urandom, $urandom, $urandom};
        end
      endcase
      chk("beat_valid", 64'(valid), 64'd1);
      chk("beat_cnt", 64'(cnt), 64'(m_cnt(k)));
      chk("beat_addr", 64'(addr), 64'(m_addr(k)));
      chk("beat_last", 64'(last), 64'(k == total - 1));
      if (ready) k++;
      else stalls++;
      cyc++;
      @(posedge clk); #1;
    end
    start = 1'b0;
    drive_cfg();
    if (k < total) begin
      chk("walk_timeout", 64'(k), 64'(total));
      return;
    end
    chk("end_valid", 64'(valid), 64'd0);
    chk("end_done", 64'(done), 64'd1);
    chk("end_busy", 64'(busy), 64'd1);
    @(posedge clk); #1;
    chk("idle_done", 64'(done), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);
`ifdef NESTN_STALL_CNT_EN
    chk("stall_cnt", 64'(stall_cnt), 64'(stalls));
`endif
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    clean  = 1'b0;
    ready  = 1'b0;
    bound  = '0;
    stride = '0;
    base   = '0;
    repeat (2) @(posedge clk);
    #1 check_zeros("reset");
    rst_n = 1'b1;

    // Dense walk: addresses run 0x100..0x10F.
    bnd = '{4, 2, 2};
    str = '{1, 4, 8};
    bas = 32'h100;
    walk(0, -1);
    walk(1, -1);

    // Singleton middle level, zero inner stride.
    bnd = '{3, 1, 5};
    str = '{0, 32'h40, 32'h1000};
    bas = 32'h2000;
    walk(0, -1);

    // Zero bound: no beat, busy and done for the single DONE cycle.
    bnd = '{3, 0, 2};
    drive_cfg();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk("zb_valid", 64'(valid), 64'd0);
    chk("zb_busy", 64'(busy), 64'd1);
    chk("zb_done", 64'(done), 64'd1);
    @(posedge clk); #1;
    chk("zb_busy_off", 64'(busy), 64'd0);
    chk("zb_done_off", 64'(done), 64'd0);
    chk("zb_valid_off", 64'(valid), 64'd0);

    // Abort at beat 7 then a clean restart.
    bnd = '{4, 2, 2};
    str = '{1, 4, 8};
    bas = 32'h100;
    walk(0, 6);
    walk(0, -1);

    // clean beats start in IDLE.
    drive_cfg();
    @(posedge clk); #1 start = 1'b1; clean = 1'b1;
    @(posedge clk); #1 start = 1'b0; clean = 1'b0;
    chk("cs_valid", 64'(valid), 64'd0);
    chk("cs_busy", 64'(busy), 64'd0);

    // Full-scale inner bound with address wrap past 2^32.
    bnd = '{255, 2, 1};
    str = '{3, 32'h100, 7};
    bas = 32'hFFFF_FF00;
    walk(0, -1);

    for (int n = 0; n < 8; n++) begin
      for (int i = 0; i < NEST; i++) begin
        bnd[i] = $urandom_range(1, 5);
        str[i] = $urandom;
      end
      bas = $urandom;
      walk(2, (n == 5) ? int'($urandom_range(0, 3)) : -1);
    end

    // Asynchronous reset mid-walk while stalled.
    bnd = '{4, 2, 2};
    str = '{1, 4, 8};
    bas = 32'h100;
    drive_cfg();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0; ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 ready = 1'b0;
    @(posedge clk); #1 rst_n = 1'b0;
    #1 check_zeros("async_rst");
    @(posedge clk); #1 rst_n = 1'b1;
    walk(0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
